// File: rtl/tt_pkg.sv
// Shared types and helpers for the truth-table sweeper and its benchmarks.
package tt_pkg;

    localparam int unsigned TT_W  = 8;
    localparam int unsigned ROW_W = 3;

    typedef logic [ROW_W-1:0] row_t;

    typedef enum logic [1:0] {
        IDLE,
        SETTLE,
        SAMPLE,
        CMP
    } state_t;

    // Row k of the gate lands in table bit (7-k), so row 000 is the MSB.
    function automatic row_t row_bit(row_t k);
        return row_t'(TT_W - 1) - k;
    endfunction

endpackage

// File: rtl/sweep_settle_timer.sv
// Settle timer: reloads on clear, counts down while enabled, strobes expire at zero.
module sweep_settle_timer #(
    parameter int unsigned CNT_W         = 8,
    parameter int unsigned SETTLE_CYCLES = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic clr_i,
    input  logic en_i,
    output logic expire_o
);

    localparam logic [CNT_W-1:0] Reload = CNT_W'(SETTLE_CYCLES - 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = Reload;
        end else if (en_i && (cnt_q != '0)) begin
            cnt_d = cnt_q - CNT_W'(1);
        end
    end

    assign expire_o = en_i && (cnt_q == '0);

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/truth_table_sweeper.sv
// Walks a 3-input gate through all 8 rows, captures its truth table and compares
// it against the expected table latched when the sweep was accepted.
module truth_table_sweeper
    import tt_pkg::*;
#(
    parameter int unsigned SETTLE_CYCLES = 4,
    parameter int unsigned CNT_W         = 8
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            start,
    input  logic            abort,
    input  logic [TT_W-1:0] exp_table,
    input  logic            dut_out,
    output logic            dut_in1,
    output logic            dut_in2,
    output logic            dut_in3,
    output logic            busy,
    output logic            done,
    output logic [TT_W-1:0] table_out,
    output logic [TT_W-1:0] mismatch,
    output logic            pass
);

    state_t            state_q, state_d;
    row_t              row_q, row_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic [TT_W-1:0]   table_q, table_d;
    logic [TT_W-1:0]   mismatch_q, mismatch_d;
    logic              pass_q, pass_d;
    logic [TT_W-1:0]   exp_q, exp_d;
    logic              timer_clr;
    logic              timer_en;
    logic              timer_expire;

    sweep_settle_timer #(
        .CNT_W        (CNT_W),
        .SETTLE_CYCLES(SETTLE_CYCLES)
    ) u_timer (
        .clk     (clk),
        .reset   (reset),
        .clr_i   (timer_clr),
        .en_i    (timer_en),
        .expire_o(timer_expire)
    );

    always_comb begin
        state_d    = state_q;
        row_d      = row_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        table_d    = table_q;
        mismatch_d = mismatch_q;
        pass_d     = pass_q;
        exp_d      = exp_q;
        timer_clr  = 1'b1;
        timer_en   = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (start) begin
                    exp_d      = exp_table;
                    table_d    = '0;
                    mismatch_d = '0;
                    pass_d     = 1'b0;
                    row_d      = '0;
                    busy_d     = 1'b1;
                    state_d    = SETTLE;
                end
            end
            SETTLE: begin
                timer_clr = 1'b0;
                timer_en  = 1'b1;
                if (timer_expire) begin
                    state_d = SAMPLE;
                end
            end
            SAMPLE: begin
                table_d[row_bit(row_q)] = dut_out;
                if (row_q == row_t'(TT_W - 1)) begin
                    state_d = CMP;
                end else begin
                    row_d   = row_q + row_t'(1);
                    state_d = SETTLE;
                end
            end
            CMP: begin
                mismatch_d = table_q ^ exp_q;
                pass_d     = (table_q == exp_q);
                done_d     = 1'b1;
                busy_d     = 1'b0;
                row_d      = '0;
                state_d    = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Abort discards whatever this cycle would have done, keeping the partial capture.
        if (abort && (state_q != IDLE)) begin
            state_d    = IDLE;
            row_d      = '0;
            busy_d     = 1'b0;
            done_d     = 1'b0;
            table_d    = table_q;
            mismatch_d = mismatch_q;
            pass_d     = pass_q;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            row_q      <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            table_q    <= '0;
            mismatch_q <= '0;
            pass_q     <= 1'b0;
            exp_q      <= '0;
        end else begin
            state_q    <= state_d;
            row_q      <= row_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            table_q    <= table_d;
            mismatch_q <= mismatch_d;
            pass_q     <= pass_d;
            exp_q      <= exp_d;
        end
    end

    assign {dut_in1, dut_in2, dut_in3} = row_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign table_out = table_q;
    assign mismatch  = mismatch_q;
    assign pass      = pass_q;

endmodule
